// File: rtl/cluster_evt_dc_pkg.sv
// Shared types and constants for the SoC<->cluster event crossing.
// CLUSTER_EVT_RX_SYNC3_EN selects a 3-flop token synchroniser instead of 2.
package cluster_evt_dc_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } rx_state_e;

   localparam int BUFFER_WIDTH_DEF = 8;
   localparam int EVNT_WIDTH_DEF   = 8;
   localparam int TOK_MAX_W        = 64;

`ifdef CLUSTER_EVT_RX_SYNC3_EN
   localparam int SYNC_STAGES = 3;
`else
   localparam int SYNC_STAGES = 2;
`endif

   // Tokens narrower than TOK_MAX_W are zero-extended by the caller.
   function automatic logic onehot_valid(input logic [TOK_MAX_W-1:0] tok);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < TOK_MAX_W; i++) begin
         cnt += 32'(tok[i]);
      end
      return (cnt == 1);
   endfunction

endpackage

// File: rtl/cluster_evt_tok_sync.sv
// Per-bit multi-flop synchroniser for a token crossing clock domains.
// Reset value is configurable so the chain matches the far side's reset token.
module cluster_evt_tok_sync #(
   parameter int               WIDTH   = 8,
   parameter int               STAGES  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_p [STAGES];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_p[i] <= RST_VAL;
         end
      end else begin
         sync_p[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_p[i] <= sync_p[i-1];
         end
      end
   end

   assign q_o = sync_p[STAGES-1];

endmodule

// File: rtl/cluster_evt_dc_rx.sv
// Cluster-side event receiver: syncs the SoC write token, pops one event per slot
// into a valid/ready stream and returns the read token. See CLUSTER_EVT_RX_SYNC3_EN.
module cluster_evt_dc_rx
   import cluster_evt_dc_pkg::*;
#(
   parameter int BUFFER_WIDTH = BUFFER_WIDTH_DEF,
   parameter int EVNT_WIDTH   = EVNT_WIDTH_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [BUFFER_WIDTH-1:0] evt_wt_i,
   input  logic [EVNT_WIDTH-1:0]   evt_da_i,
   output logic [BUFFER_WIDTH-1:0] evt_rp_o,
   output logic                    evt_valid_o,
   input  logic                    evt_ready_i,
   output logic [EVNT_WIDTH-1:0]   evt_data_o,
   output logic                    tok_err_o
);

   logic [BUFFER_WIDTH-1:0] wt_s;
   logic [BUFFER_WIDTH-1:0] rp_q;
   logic [EVNT_WIDTH-1:0]   data_p0;
   logic                    vld_p0;
   logic                    tok_err_q;
   rx_state_e               state_q;
   logic                    tok_ok;
   logic                    empty;
   logic                    slot_free;
   logic                    pop;

   cluster_evt_tok_sync #(
      .WIDTH   (BUFFER_WIDTH),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (BUFFER_WIDTH'(1))
   ) u_wt_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (evt_wt_i),
      .q_o   (wt_s)
   );

   assign tok_ok    = onehot_valid(TOK_MAX_W'(wt_s));
   assign empty     = (wt_s == rp_q);
   assign slot_free = !vld_p0 || evt_ready_i;
   assign pop       = (state_q == IDLE) && !empty && slot_free && tok_ok;

   // Pop stage: capture the slot selected by rp_q, then advance the read token.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rp_q      <= BUFFER_WIDTH'(1);
         vld_p0    <= 1'b0;
         data_p0   <= '0;
         tok_err_q <= 1'b0;
      end else begin
         if (!tok_ok) begin
            tok_err_q <= 1'b1;
         end
         // SETTLE gives evt_da_i a cycle to follow the new rp through the SoC mux.
         case (state_q)
            IDLE:    state_q <= pop ? SETTLE : IDLE;
            SETTLE:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (pop) begin
            rp_q    <= (rp_q << 1) | (rp_q >> (BUFFER_WIDTH-1));
            vld_p0  <= 1'b1;
            data_p0 <= evt_da_i;
         end else if (evt_ready_i) begin
            vld_p0  <= 1'b0;
         end
      end
   end

   assign evt_rp_o    = rp_q;
   assign evt_valid_o = vld_p0;
   assign evt_data_o  = data_p0;
   assign tok_err_o   = tok_err_q;

endmodule

// File: tb/tb_cluster_evt_dc_rx.sv
// Self-checking bench for cluster_evt_dc_rx with a behavioural SoC-side buffer model.
// Honours CLUSTER_EVT_RX_SYNC3_EN for the expected token-to-valid latency.
module tb_cluster_evt_dc_rx;

   localparam int BW = 8;
   localparam int EW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] evt_wt;
   logic [EW-1:0] evt_da;
   logic [BW-1:0] evt_rp;
   logic          evt_valid;
   logic          evt_ready;
   logic [EW-1:0] evt_data;
   logic          tok_err;

   logic [EW-1:0] mem [BW];
   int            wr_idx;
   int            errors = 0;
   int            checks = 0;
   int            lat_exp;

   always #5 clk = ~clk;

   cluster_evt_dc_rx #(
      .BUFFER_WIDTH (BW),
      .EVNT_WIDTH   (EW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .evt_wt_i    (evt_wt),
      .evt_da_i    (evt_da),
      .evt_rp_o    (evt_rp),
      .evt_valid_o (evt_valid),
      .evt_ready_i (evt_ready),
      .evt_data_o  (evt_data),
      .tok_err_o   (tok_err)
   );

   // SoC-side buffer read mux, addressed by the returned read token.
   always_comb begin
      evt_da = '0;
      for (int i = 0; i < BW; i++) begin
         if (evt_rp == (BW'(1) << i)) evt_da = mem[i];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Writer: store word in the next slot, then advance the one-hot write token.
   task automatic push(input logic [EW-1:0] w);
      mem[wr_idx] = w;
      wr_idx      = (wr_idx + 1) % BW;
      evt_wt      = BW'(1) << wr_idx;
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      evt_wt    = BW'(1);
      evt_ready = 1'b0;
      wr_idx    = 0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if (evt_rp !== 8'h01) begin errors++; $display("FAIL reset_rp: got %h want 01", evt_rp); end
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
      checks++;
      if (tok_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", tok_err); end
      checks++;
      if (evt_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", evt_data); end
   endtask

   task automatic test_single;
      int n;
      do_reset();
      evt_ready = 1'b1;
      push(8'hA5);
      n = 0;
      for (int i = 1; i <= 10 && n == 0; i++) begin
         tick();
         if (evt_valid === 1'b1) n = i;
      end
      checks++;
      if (n !== lat_exp) begin errors++; $display("FAIL single_latency: got %0d edges want %0d", n, lat_exp); end
      checks++;
      if (evt_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", evt_data); end
      checks++;
      if (evt_rp !== 8'h02) begin errors++; $display("FAIL single_rp: got %h want 02", evt_rp); end
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_valid_fall: got %b want 0", evt_valid); end
   endtask

   task automatic test_backpressure;
      logic [EW-1:0] w0, w1;
      logic          got;
      do_reset();
      w0 = EW'($urandom);
      w1 = EW'($urandom);
      push(w0);
      push(w1);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (evt_valid === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got || evt_data !== w0) begin errors++; $display("FAIL bp_first: valid=%b data=%h want %h", evt_valid, evt_data, w0); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({evt_valid, evt_data, evt_rp} !== {1'b1, w0, 8'h02}) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h rp=%h want 1 %h 02", evt_valid, evt_data, evt_rp, w0);
         end
      end
      evt_ready = 1'b1;
      tick();
      checks++;
      if ({evt_valid, evt_data, evt_rp} !== {1'b1, w1, 8'h04}) begin
         errors++;
         $display("FAIL bp_second: valid=%b data=%h rp=%h want 1 %h 04", evt_valid, evt_data, evt_rp, w1);
      end
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", evt_valid); end
   endtask

   task automatic test_back_to_back;
      logic [EW-1:0] q[$];
      logic [EW-1:0] w, exp_w;
      logic [BW-1:0] prev_rp;
      int            pushed, pops, last;
      do_reset();
      evt_ready = 1'b1;
      for (int i = 0; i < BW - 1; i++) begin
         w = EW'($urandom);
         q.push_back(w);
         push(w);
      end
      pushed  = BW - 1;
      pops    = 0;
      last    = -1;
      prev_rp = evt_rp;
      for (int cyc = 0; cyc < 80 && pops < BW; cyc++) begin
         tick();
         if (evt_rp !== prev_rp) begin
            pops++;
            exp_w = (q.size() > 0) ? q.pop_front() : '0;
            checks++;
            if (evt_valid !== 1'b1 || evt_data !== exp_w) begin
               errors++;
               $display("FAIL b2b_word%0d: valid=%b data=%h want 1 %h", pops, evt_valid, evt_data, exp_w);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last !== 2) begin errors++; $display("FAIL b2b_spacing%0d: got %0d want 2", pops, cyc - last); end
            end
            last    = cyc;
            prev_rp = evt_rp;
            if (pushed < BW) begin
               w = EW'($urandom);
               q.push_back(w);
               push(w);
               pushed++;
            end
         end
      end
      checks++;
      if (pops !== BW) begin errors++; $display("FAIL b2b_count: got %0d want %0d", pops, BW); end
      checks++;
      if (evt_rp !== 8'h01) begin errors++; $display("FAIL b2b_wrap_rp: got %h want 01", evt_rp); end
   endtask

   task automatic test_bad_token;
      int n;
      logic got;
      do_reset();
      evt_ready = 1'b1;
      evt_wt    = 8'h03;
      n = 0;
      for (int i = 1; i <= 6 && n == 0; i++) begin
         tick();
         if (tok_err === 1'b1) n = i;
      end
      checks++;
      if (n == 0 || n > lat_exp) begin errors++; $display("FAIL bad_err_set: got edge %0d want 1..%0d", n, lat_exp); end
      checks++;
      if ({evt_valid, evt_rp} !== {1'b0, 8'h01}) begin
         errors++;
         $display("FAIL bad_no_pop: valid=%b rp=%h want 0 01", evt_valid, evt_rp);
      end
      evt_wt = 8'h01;
      repeat (4) tick();
      checks++;
      if ({tok_err, evt_valid, evt_rp} !== {1'b1, 1'b0, 8'h01}) begin
         errors++;
         $display("FAIL bad_sticky: err=%b valid=%b rp=%h want 1 0 01", tok_err, evt_valid, evt_rp);
      end
      push(8'h3C);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (evt_valid === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got || evt_data !== 8'h3C || tok_err !== 1'b1) begin
         errors++;
         $display("FAIL bad_recover: valid=%b data=%h err=%b want 1 3c 1", evt_valid, evt_data, tok_err);
      end
      do_reset();
      checks++;
      if (tok_err !== 1'b0) begin errors++; $display("FAIL bad_err_clear: got %b want 0", tok_err); end
   endtask

   task automatic test_reset_mid;
      logic got;
      do_reset();
      evt_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(EW'($urandom));
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (evt_rp === 8'h10) got = 1'b1;
      end
      checks++;
      if (!got || evt_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: rp=%h valid=%b want 10 1", evt_rp, evt_valid); end
      rst    = 1'b1;
      evt_wt = BW'(1);
      wr_idx = 0;
      tick();
      rst = 1'b0;
      checks++;
      if ({evt_valid, evt_rp, evt_data} !== {1'b0, 8'h01, 8'h00}) begin
         errors++;
         $display("FAIL mid_reset: valid=%b rp=%h data=%h want 0 01 00", evt_valid, evt_rp, evt_data);
      end
   endtask

   initial begin
`ifdef CLUSTER_EVT_RX_SYNC3_EN
      lat_exp = 4;
`else
      lat_exp = 3;
`endif
      for (int i = 0; i < BW; i++) mem[i] = '0;
      rst       = 1'b1;
      evt_wt    = BW'(1);
      evt_ready = 1'b0;
      wr_idx    = 0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_bad_token();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
